// File: rtl/div_sequencer_pkg.sv
// Shared ALU definitions: divider sequencer states and NZCV flag bit positions.
package div_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/div_sequencer_subtract.sv
// ALU subtract unit: s = a - b with NZCV flags; C is the borrow (1 when a < b unsigned).
module subtract
  import div_sequencer_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s,
  output logic [3:0]   flags
);

  logic borrow;

  always_comb begin
    {borrow, s}   = {1'b0, a} - {1'b0, b};
    flags         = '0;
    flags[FLAG_N] = s[W-1];
    flags[FLAG_Z] = (s == '0);
    flags[FLAG_C] = borrow;
    flags[FLAG_V] = (a[W-1] ^ b[W-1]) & (s[W-1] ^ a[W-1]);
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring unsigned divider: N subtract steps, then a one-cycle DONE
// that publishes quotient, remainder and NZCV flags with a done pulse.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic [3:0]   flags
);

  localparam int CW = $clog2(N);

  div_state_t    state, state_nxt;
  logic [CW-1:0] count;
  logic [N-1:0]  rem_r, quo_r, divisor_r;
  logic          dz_r;
  logic [N:0]    trial, diff;
  logic [3:0]    sub_flags;
  logic          borrow;
  logic          sub_unused;

  function automatic logic [3:0] quotient_flags(input logic [N-1:0] q);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = q[N-1];
    f[FLAG_Z] = (q == '0);
    return f;
  endfunction

  assign trial = {rem_r, quo_r[N-1]};

  subtract #(.W(N + 1)) u_subtract (
    .a     (trial),
    .b     ({1'b0, divisor_r}),
    .s     (diff),
    .flags (sub_flags)
  );

  assign borrow     = sub_flags[FLAG_C];
  assign sub_unused = ^{sub_flags[FLAG_V], sub_flags[FLAG_Z], sub_flags[FLAG_N], diff[N]};
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (divisor == '0) ? DONE : RUN;
      RUN:     if (count == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      divisor_r   <= '0;
      dz_r        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      flags       <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            divisor_r <= divisor;
            dz_r      <= (divisor == '0);
            // Divide-by-zero preloads the final answer so DONE publishes it unchanged.
            if (divisor == '0) begin
              rem_r <= dividend;
              quo_r <= '1;
            end else begin
              rem_r <= '0;
              quo_r <= dividend;
              count <= CW'(N - 1);
            end
          end
        end
        RUN: begin
          rem_r <= borrow ? trial[N-1:0] : diff[N-1:0];
          quo_r <= {quo_r[N-2:0], ~borrow};
          count <= count - CW'(1);
        end
        DONE: begin
          quotient    <= quo_r;
          remainder   <= rem_r;
          div_by_zero <= dz_r;
          flags       <= quotient_flags(quo_r);
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer (N=8): directed cases plus randomized traffic
// compared every cycle against a latency/arithmetic reference model.
module tb_div_sequencer;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [N-1:0] quotient, remainder;
  logic [3:0]   flags;

  int n_cmp = 0;
  int n_fail = 0;

  div_sequencer #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .flags       (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request finishes N+1 edges later (1 edge for
  // divide-by-zero); results come from plain / and %.
  logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
  logic [N-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
  logic [3:0]   m_flags = '0;
  int           m_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_dz    <= 1'b0;
      m_q     <= '0;
      m_r     <= '0;
      m_flags <= '0;
      m_cnt   <= 0;
    end else begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy <= 1'b1;
          m_cnt  <= (divisor == 0) ? 1 : N + 1;
          p_dz   <= (divisor == 0);
          p_q    <= (divisor == 0) ? {N{1'b1}} : dividend / divisor;
          p_r    <= (divisor == 0) ? dividend : dividend % divisor;
        end
      end else if (m_cnt == 1) begin
        m_busy  <= 1'b0;
        m_done  <= 1'b1;
        m_q     <= p_q;
        m_r     <= p_r;
        m_dz    <= p_dz;
        m_flags <= {2'b00, (p_q == 0), p_q[N-1]};
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("quotient", quotient, m_q);
    chk("remainder", remainder, m_r);
    chk("div_by_zero", div_by_zero, m_dz);
    chk("flags", flags, m_flags);
  end

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b, output int lat);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = N'($urandom); divisor = N'($urandom);
    wait_done(lat);
  endtask

  task automatic chk_result(input string name, input logic [N-1:0] q, input logic [N-1:0] r,
                            input logic dz, input logic [3:0] f);
    chk({name, "_q"}, quotient, q);
    chk({name, "_r"}, remainder, r);
    chk({name, "_dz"}, div_by_zero, dz);
    chk({name, "_flags"}, flags, f);
  endtask

  initial begin
    int lat;
    int guard;
    repeat (3) @(negedge clk);
    chk_result("reset", 8'd0, 8'd0, 1'b0, 4'b0000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_div(8'd100, 8'd7, lat);
    chk("lat_100_7", lat, 10);
    chk_result("d100_7", 8'd14, 8'd2, 1'b0, 4'b0000);
    chk("model_q_100_7", m_q, 8'd14);
    chk("model_r_100_7", m_r, 8'd2);

    run_div(8'd5, 8'd9, lat);
    chk_result("d5_9", 8'd0, 8'd5, 1'b0, 4'b0010);

    run_div(8'd255, 8'd1, lat);
    chk_result("d255_1", 8'd255, 8'd0, 1'b0, 4'b0001);
    run_div(8'd255, 8'd255, lat);
    chk_result("d255_255", 8'd1, 8'd0, 1'b0, 4'b0000);

    run_div(8'd42, 8'd0, lat);
    chk("lat_42_0", lat, 2);
    chk_result("d42_0", 8'hFF, 8'd42, 1'b1, 4'b0001);
    chk("model_flags_42_0", m_flags, 4'b0001);

    // A start during RUN must be dropped, not queued.
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    lat = 0;
    wait_done(lat);
    chk_result("ignored", 8'd14, 8'd2, 1'b0, 4'b0000);
    run_div(8'd9, 8'd3, lat);
    chk_result("d9_3", 8'd3, 8'd0, 1'b0, 4'b0000);

    // Reset in the middle of RUN.
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_result("abort", 8'd0, 8'd0, 1'b0, 4'b0000);
    chk("abort_busy", busy, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 1'b0);
      if (i == 2) #2 rst_n = 1'b1;
    end
    run_div(8'd200, 8'd3, lat);
    chk_result("d200_3", 8'd66, 8'd2, 1'b0, 4'b0000);

    // Randomized traffic, including starts while busy.
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      dividend = N'($urandom);
      case ($urandom_range(0, 7))
        0:       divisor = 8'd0;
        1:       divisor = 8'd1;
        2:       divisor = 8'hFF;
        3:       divisor = N'($urandom_range(2, 15));
        default: divisor = N'($urandom);
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    guard = 0;
    while (busy && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("final_idle", busy, 1'b0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
